apu_reg_bank: RTL

- Parametrised multi-channel APU register bank for CPU-side writes. Each of CHANNELS channels owns REGS_PER_CH registers.
- One extra status/enable register follows the channel registers.
- Outputs: per-register one-cycle write strobes, per-channel enable bits, and sticky per-channel restart requests with an acknowledge handshake to the channel logic.
- Sits between the CPU bus decoder and the pulse, triangle, noise and DMC channel blocks; replaces the fixed 4-register bank.

---
 rtl/apu_reg_bank_if.sv | 10 +
 rtl/apu_reg_bank.sv | 83 ++++++++
 2 files changed

// File: rtl/apu_reg_bank_if.sv
// apu_reg_bank_if: CPU-side bus into the APU register bank (address, data, rw, select, read data).
interface apu_reg_bank_if #(parameter int DATA_W = 8);
  logic [15:0]       sys_addr;
  logic [DATA_W-1:0] sys_data;
  logic              sys_rw;
  logic              sel;
  logic [DATA_W-1:0] rd_data;
  modport master (output sys_addr, sys_data, sys_rw, sel, input rd_data);
  modport slave  (input sys_addr, sys_data, sys_rw, sel, output rd_data);
endinterface

// File: rtl/apu_reg_bank.sv
// apu_reg_bank: multi-channel APU register bank with write strobes, channel enables and restart handshake.
// Define APU_REG_READBACK_EN to return register contents and enables on reads.
module apu_reg_bank #(
  parameter int CHANNELS    = 5,
  parameter int REGS_PER_CH = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5
) (
  input  logic                                   dclk,
  input  logic                                   n_reset,
  apu_reg_bank_if.slave                          bus,
  output logic [CHANNELS*REGS_PER_CH*DATA_W-1:0] o_regs,
  output logic [CHANNELS*REGS_PER_CH-1:0]        o_wr_strobe,
  output logic [CHANNELS-1:0]                    o_enable,
  output logic [CHANNELS-1:0]                    o_restart_req,
  input  logic [CHANNELS-1:0]                    i_restart_ack
);
  localparam int NREG       = CHANNELS * REGS_PER_CH;
  localparam int STATUS_IDX = NREG;
  logic [DATA_W-1:0]            r_regs [NREG];
  logic [NREG-1:0]              r_strobe;
  logic [CHANNELS-1:0]          r_enable;
  logic [CHANNELS-1:0]          r_restart;
  logic [DATA_W-1:0]            r_rd;
  logic                         w_we;
  logic                         w_re;
  logic                         w_status_wr;
  logic [ADDR_W-1:0]            w_idx;
  logic [NREG-1:0]              w_hit;
  logic [CHANNELS-1:0]          w_set;
  logic [CHANNELS-1:0]          w_keep;
  logic [DATA_W-1:0]            w_rd_val;
  logic [DATA_W+2*CHANNELS-1:0] w_stat;
  logic                         w_unused;
  assign w_we        = bus.sel & bus.sys_rw;
  assign w_re        = bus.sel & ~bus.sys_rw;
  assign w_idx       = bus.sys_addr[ADDR_W-1:0];
  assign w_status_wr = w_we && w_idx == ADDR_W'(STATUS_IDX);
  // channels being disabled by a status write drop their pending restart
  assign w_keep      = w_status_wr ? bus.sys_data[CHANNELS-1:0] : '1;
`ifdef APU_REG_READBACK_EN
  assign w_stat = {{DATA_W{1'b0}}, r_enable, r_restart};
`else
  assign w_stat = {{(DATA_W+CHANNELS){1'b0}}, r_restart};
`endif
  assign w_unused = ^{bus.sys_addr[15:ADDR_W], w_stat[DATA_W+2*CHANNELS-1:DATA_W]};
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NREG; i++) w_hit[i] = w_we && w_idx == ADDR_W'(i);
  end
  always_comb begin
    w_set = '0;
    for (int c = 0; c < CHANNELS; c++) w_set[c] = w_hit[c*REGS_PER_CH+REGS_PER_CH-1] & r_enable[c];
  end
  always_comb begin
    w_rd_val = w_idx == ADDR_W'(STATUS_IDX) ? w_stat[DATA_W-1:0] : '0;
`ifdef APU_REG_READBACK_EN
    for (int i = 0; i < NREG; i++) if (w_idx == ADDR_W'(i)) w_rd_val = r_regs[i];
`endif
  end
  always_ff @(posedge dclk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_strobe  <= '0;
      r_enable  <= '0;
      r_restart <= '0;
      r_rd      <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) if (w_hit[i]) r_regs[i] <= bus.sys_data;
      r_strobe <= w_hit;
      if (w_status_wr) r_enable <= bus.sys_data[CHANNELS-1:0];
      r_restart <= w_set | (r_restart & ~i_restart_ack & w_keep);
      if (w_re) r_rd <= w_rd_val;
    end
  end
  for (genvar i = 0; i < NREG; i++) begin : g_regs
    assign o_regs[i*DATA_W +: DATA_W] = r_regs[i];
  end
  assign o_wr_strobe   = r_strobe;
  assign o_enable      = r_enable;
  assign o_restart_req = r_restart;
  assign bus.rd_data   = r_rd;
endmodule
